// File: rtl/fp32_iterative_divider.sv
// Multi-cycle IEEE-754 binary32 divider (lhs / rhs), radix-2 restoring, one op in flight.
// Fixed latency for every input; special cases ride through the same schedule.
module fp32_iterative_divider #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req,
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned NumCycles = 26 / BITS_PER_CYCLE;
   localparam logic [4:0]  LastCnt   = 5'(NumCycles - 1);
   localparam logic [31:0] QNaN      = 32'h7fc0_0000;

   typedef enum logic [1:0] {StIdle, StDivide, StRound, StDone} state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic signed [9:0] exp_q, exp_d;
   logic [25:0]       rem_q, rem_d;
   logic [23:0]       div_q, div_d;
   logic [25:0]       quo_q, quo_d;
   logic              spec_q, spec_d;
   logic [31:0]       spec_res_q, spec_res_d;
   logic [31:0]       result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Leading-zero count of a 23-bit fraction (value irrelevant for an all-zero fraction).
   function automatic logic [4:0] lzc23(input logic [22:0] f);
      logic [4:0] n;
      logic       hit;
      n   = 5'd0;
      hit = 1'b0;
      for (int i = 22; i >= 0; i--) begin
         if (!hit && f[i]) begin
            n   = 5'(22 - i);
            hit = 1'b1;
         end
      end
      return n;
   endfunction

   // Returns {virtual exponent, normalised 24-bit mantissa with leading one at bit 23}.
   function automatic logic [33:0] unpack(input logic [31:0] x);
      logic [4:0]  lz;
      logic [23:0] m;
      logic [9:0]  ve;
      lz = lzc23(x[22:0]);
      if (x[30:23] != 8'd0) begin
         m  = {1'b1, x[22:0]};
         ve = {2'b00, x[30:23]};
      end else begin
         m  = {1'b0, x[22:0]} << (lz + 5'd1);
         ve = 10'd0 - {5'd0, lz};
      end
      return {ve, m};
   endfunction

   logic [23:0]       mant_l, mant_r;
   logic signed [9:0] ve_l, ve_r, e_pre;
   logic [25:0]       rem_init;
   logic signed [9:0] exp_init;
   logic              sign_init;
   logic              spec_init;
   logic [31:0]       spec_res_init;
   logic              nan_l, nan_r, inf_l, inf_r, zero_l, zero_r;

   // Accept-edge preparation: classify, normalise, pre-align so the quotient lands in [1,2).
   always_comb begin
      {ve_l, mant_l} = unpack(lhs);
      {ve_r, mant_r} = unpack(rhs);
      sign_init = lhs[31] ^ rhs[31];
      e_pre     = ve_l - ve_r + 10'sd127;
      if (mant_l < mant_r) begin
         rem_init = {1'b0, mant_l, 1'b0};
         exp_init = e_pre - 10'sd1;
      end else begin
         rem_init = {2'b00, mant_l};
         exp_init = e_pre;
      end
      nan_l  = (lhs[30:23] == 8'hff) && (lhs[22:0] != 23'd0);
      nan_r  = (rhs[30:23] == 8'hff) && (rhs[22:0] != 23'd0);
      inf_l  = (lhs[30:23] == 8'hff) && (lhs[22:0] == 23'd0);
      inf_r  = (rhs[30:23] == 8'hff) && (rhs[22:0] == 23'd0);
      zero_l = (lhs[30:0] == 31'd0);
      zero_r = (rhs[30:0] == 31'd0);
      spec_init     = 1'b1;
      spec_res_init = QNaN;
      if (nan_l || nan_r || (zero_l && zero_r) || (inf_l && inf_r)) begin
         spec_res_init = QNaN;
      end else if (inf_l || zero_r) begin
         spec_res_init = {sign_init, 8'hff, 23'd0};
      end else if (zero_l || inf_r) begin
         spec_res_init = {sign_init, 31'd0};
      end else begin
         spec_init = 1'b0;
      end
   end

   logic [25:0] rem_step, quo_step;
   logic [26:0] diff;
   logic        qbit;

   // Restoring division: BITS_PER_CYCLE trial subtractions chained per cycle.
   always_comb begin
      rem_step = rem_q;
      quo_step = quo_q;
      diff     = 27'd0;
      qbit     = 1'b0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         diff = {1'b0, rem_step} - {3'b000, div_q};
         qbit = ~diff[26];
         if (qbit) begin
            rem_step = diff[25:0];
         end
         rem_step = {rem_step[24:0], 1'b0};
         quo_step = {quo_step[24:0], qbit};
      end
   end

   logic signed [9:0] sh_s;
   logic [9:0]        sh_u;
   logic [25:0]       q_sh, mask;
   logic              sticky, round_up;
   logic [7:0]        field_base;
   logic [30:0]       mag;
   logic [31:0]       round_res;

   // Denormalise if needed, then round to nearest even; carry ripples into the exponent.
   always_comb begin
      sh_s       = 10'sd1 - exp_q;
      sh_u       = sh_s;
      mask       = 26'd0;
      q_sh       = quo_q;
      sticky     = |rem_q;
      field_base = 8'd0;
      if (exp_q >= 10'sd1) begin
         // Hidden one from q_sh[25] adds back the 1 subtracted here.
         field_base = exp_q[7:0] - 8'd1;
      end else if (sh_u >= 10'd26) begin
         q_sh   = 26'd0;
         sticky = 1'b1;
      end else begin
         mask   = (26'd1 << sh_u) - 26'd1;
         q_sh   = quo_q >> sh_u;
         sticky = sticky | (|(quo_q & mask));
      end
      round_up = q_sh[1] & (q_sh[0] | sticky | q_sh[2]);
      mag      = {field_base, 23'd0} + {7'd0, q_sh[25:2]} + {30'd0, round_up};
      if (exp_q >= 10'sd255) begin
         round_res = {sign_q, 8'hff, 23'd0};
      end else begin
         round_res = {sign_q, mag};
      end
   end

   logic accept;

   // Next-state logic: sequencing, operand load, result capture; flush overrides all.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      rem_d      = rem_q;
      div_d      = div_q;
      quo_d      = quo_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      accept     = req && !flush && ((state_q == StIdle) || (state_q == StDone));
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               state_d    = StDivide;
               cnt_d      = 5'd0;
               sign_d     = sign_init;
               exp_d      = exp_init;
               rem_d      = rem_init;
               div_d      = mant_r;
               quo_d      = 26'd0;
               spec_d     = spec_init;
               spec_res_d = spec_res_init;
            end
         end
         StDivide: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LastCnt) begin
               state_d = StRound;
            end
         end
         StRound: begin
            result_d = spec_q ? spec_res_q : round_res;
            state_d  = StDone;
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
      busy_d = (state_d == StDivide) || (state_d == StRound);
      done_d = (state_d == StDone);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         sign_q     <= 1'b0;
         exp_q      <= 10'sd0;
         rem_q      <= 26'd0;
         div_q      <= 24'd0;
         quo_q      <= 26'd0;
         spec_q     <= 1'b0;
         spec_res_q <= 32'd0;
         result_q   <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         quo_q      <= quo_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
